// File: rtl/shift_arb_pkg.sv
// Shared types for the shift-unit arbiter.
//   shift_sel_e  : 2-bit shift amount select (0..3 bit positions)
//   slot_state_e : occupancy of the single-entry output register
package shift_arb_pkg;

  typedef enum logic [1:0] {
    SH0 = 2'd0,
    SH1 = 2'd1,
    SH2 = 2'd2,
    SH3 = 2'd3
  } shift_sel_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage : shift_arb_pkg

// File: rtl/shift_sel_unit.sv
// Combinational select-controlled left shifter.
// Ports:
//   x      : operand
//   s      : shift amount select (SH0..SH3)
//   result : x << s, truncated to WIDTH, zeros fill the LSBs
module shift_sel_unit
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  shift_sel_e       s,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    case (s)
      SH0:     result = x;
      SH1:     result = x << 1;
      SH2:     result = x << 2;
      SH3:     result = x << 3;
      default: result = '0;
    endcase
  end

endmodule : shift_sel_unit

// File: rtl/shift_unit_arbiter.sv
// Round-robin scheduler sharing one left-shift unit among NUM_REQ requesters.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester request valid
//   req_data   : per-requester operand, slice i = [i*WIDTH +: WIDTH]
//   req_sel    : per-requester shift select, slice i = [2*i +: 2]
//   req_ready  : one-hot (or zero) acceptance, combinational
//   out_valid  : output register holds a result
//   out_ready  : consumer accepts the held result
//   out_data   : shifted result
//   out_id     : index of the requester that produced out_data
//   op_count   : completed output handshakes, wrapping
module shift_unit_arbiter
  import shift_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [2*NUM_REQ-1:0]       req_sel,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic [CNT_W-1:0]           op_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int IDX_W = ID_W + 1;

  slot_state_e      state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [CNT_W-1:0] op_count_q;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic [IDX_W-1:0] cand;
  logic [WIDTH-1:0] gnt_data;
  logic [1:0]       gnt_sel;
  logic [WIDTH-1:0] shift_res;
  logic             can_accept;
  logic             accept;
  logic             drain;

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign op_count  = op_count_q;

  // A result leaving this cycle frees the slot for a new one (no bubble).
  assign can_accept = !out_valid || out_ready;
  assign drain      = out_valid && out_ready;
  assign accept     = gnt_found && can_accept;

  // Round-robin search: first valid index at or after rr_ptr, wrapping.
  // NOTE: every variable driven in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (cand >= IDX_W'(NUM_REQ)) begin
        cand = cand - IDX_W'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Operand/select mux for the granted requester.
  always_comb begin
    gnt_data = '0;
    gnt_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        gnt_data = req_data[i*WIDTH +: WIDTH];
        gnt_sel  = req_sel[2*i +: 2];
      end
    end
  end

  // Held low while rst is asserted so no handshake can appear during reset.
  always_comb begin
    req_ready = '0;
    if (accept && !rst) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  shift_sel_unit #(
    .WIDTH (WIDTH)
  ) u_shift (
    .x      (gnt_data),
    .s      (shift_sel_e'(gnt_sel)),
    .result (shift_res)
  );

  // Output-slot FSM; loading a new result also advances the pointer.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready && !accept) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      out_data_d = shift_res;
      out_id_d   = gnt_idx;
      rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      if (drain) begin
        op_count_q <= op_count_q + 1'b1;
      end
    end
  end

endmodule : shift_unit_arbiter

// File: tb/tb_shift_unit_arbiter.sv
// Self-checking bench for shift_unit_arbiter (WIDTH=8, NUM_REQ=4, CNT_W=4).
// A behavioural model tracks the expected output slot, pointer and counter;
// a compare process checks every falling edge, and directed sections pin
// hand-computed literal values.
module tb_shift_unit_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [2*NUM_REQ-1:0]     req_sel;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [1:0]               out_id;
  logic [CNT_W-1:0]         op_count;

  int n_checks = 0;
  int n_err    = 0;

  shift_unit_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;
  int         m_cnt;

  // Winner = valid requester with the smallest circular distance from ptr.
  function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
    int best  = -1;
    int bestd = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) begin
        int d = (i - ptr + NUM_REQ) % NUM_REQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] model_shift(input logic [7:0] x, input logic [1:0] s);
    logic [31:0] p;
    p = 32'(x) * (32'd1 << s);
    return p[7:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] model_ready();
    int g = model_grant(req_valid, m_ptr);
    if (rst || g < 0 || !(!m_valid || out_ready)) return '0;
    return NUM_REQ'(1) << g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else begin
      int  g;
      logic can;
      g   = model_grant(req_valid, m_ptr);
      can = !m_valid || out_ready;
      if (m_valid && out_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (can && g >= 0) begin
        m_data  = model_shift(req_data[g*WIDTH +: WIDTH], req_sel[2*g +: 2]);
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NUM_REQ;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(model_ready()));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("op_count", 32'(op_count), 32'(m_cnt));
    if (m_valid) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_id", 32'(out_id), 32'(m_id));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] s);
    req_data[i*WIDTH +: WIDTH] = d;
    req_sel[2*i +: 2]          = s;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst       = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_sel   = '0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset state, with requests present.
    req_valid = 4'hF;
    at_neg();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_id", 32'(out_id), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = '0;

    // Basic: req0 0x13 sel 01 -> 0x26.
    set_req(0, 8'h13, 2'b01);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    rst       = 1'b0;
    at_neg();
    check("basic_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    at_neg();
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_data", 32'(out_data), 32'h26);
    check("basic_id", 32'(out_id), 32'h0);
    check("basic_cnt0", 32'(op_count), 32'h0);
    tick();
    at_neg();
    check("basic_cnt1", 32'(op_count), 32'h1);
    check("basic_drained", 32'(out_valid), 32'h0);

    // Truncation: req2 0xFF sel 11 -> 0xF8.
    tick();
    set_req(2, 8'hFF, 2'b11);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    at_neg();
    check("trunc_data", 32'(out_data), 32'hF8);
    check("trunc_id", 32'(out_id), 32'h2);
    tick();

    // Fairness: all valid, out_ready high.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i + 1), 2'b00);
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      at_neg();
      check("fair_id", 32'(out_id), 32'(i % NUM_REQ));
      check("fair_valid", 32'(out_valid), 32'h1);
    end
    tick();
    req_valid = '0;

    // Backpressure: 0x10 sel 10 -> 0x40 from req1, held for 5 cycles.
    do_reset();
    out_ready = 1'b0;
    set_req(1, 8'h10, 2'b10);
    req_valid = 4'b0010;
    tick();
    set_req(3, 8'h05, 2'b00);
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("bp_data", 32'(out_data), 32'h40);
      check("bp_id", 32'(out_id), 32'h1);
      check("bp_ready", 32'(req_ready), 32'h0);
    end
    tick();
    out_ready = 1'b1;
    at_neg();
    check("bp_release_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    at_neg();
    check("bp_next_valid", 32'(out_valid), 32'h1);
    check("bp_next_data", 32'(out_data), 32'h05);
    check("bp_next_id", 32'(out_id), 32'h3);
    tick();

    // Reset mid-operation: FULL with rr_ptr=3.
    do_reset();
    out_ready = 1'b0;
    set_req(2, 8'h01, 2'b00);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    rst       = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    req_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    check("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    at_neg();
    check("post_rst_id", 32'(out_id), 32'h0);
    tick();
    req_valid = '0;

    // Counter wrap: 17 handshakes with a 4-bit counter reads 1.
    do_reset();
    set_req(0, 8'h55, 2'b00);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    repeat (18) @(posedge clk);
    at_neg();
    check("cnt_wrap", 32'(op_count), 32'h1);
    tick();
    req_valid = '0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      req_valid = NUM_REQ'($urandom);
      req_data  = ($urandom);
      req_sel   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_shift_unit_arbiter

// File: doc/shift_unit_arbiter.md
# shift_unit_arbiter

Round-robin scheduler sharing one select-controlled left-shift unit among `NUM_REQ` requesters. Each requester presents an operand and a 2-bit shift select via valid/ready handshake. The arbiter grants one request per cycle, computes `x << sel` (0..3 bits) and holds the result in a single-entry output register with valid/ready handshake and requester ID. It sits between the requesters and a downstream consumer.

## Interface
- `WIDTH`, 8, operand/result width
- `NUM_REQ`, 4, number of requesters (≥2)
- `CNT_W`, 16, width of completed-operation counter
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req_valid`  input  NUM_REQ  request valid, bit i = requester i
- `req_data`  input  NUM_REQ*WIDTH  operands, slice i = `[i*WIDTH +: WIDTH]`
- `req_sel`  input  2*NUM_REQ  shift selects, slice i = `[2*i +: 2]`
- `req_ready`  output  NUM_REQ  one-hot or zero; request i accepted when `req_valid[i] && req_ready[i]`
- `out_valid`  output  1  result held
- `out_ready`  input  1  consumer accepts
- `out_data`  output  WIDTH  shifted result
- `out_id`  output  $clog2(NUM_REQ)  index of originating requester
- `op_count`  output  CNT_W  completed output handshakes, wraps

## Operation
- Shift: sel 00→x, 01→x<<1, 10→x<<2, 11→x<<3; result truncated to WIDTH (bits shifted out dropped, zeros fill LSBs).
- `can_accept = !out_valid || out_ready` (a buffered result draining this cycle frees the slot).
- Arbitration: among asserted `req_valid`, grant the first index at or after `rr_ptr`, searching upward with wrap-around. `req_ready[g] = can_accept` for granted index g; all other bits 0. No valid requests → `req_ready` all 0.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr`, `out_valid`, `out_ready`; requesters must not make `req_valid` depend on `req_ready`.
- On accept: `out_data`←shift result, `out_id`←g, `out_valid`←1, `rr_ptr`←(g+1) mod NUM_REQ.
- `rr_ptr` advances only on accept; unaccepted requests do not move it.
- State machine (output slot): EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY + accept → FULL; EMPTY + no accept → EMPTY.
  - FULL + `out_ready` + accept → FULL with new data (back-to-back).
  - FULL + `out_ready` + no accept → EMPTY.
  - FULL + !`out_ready` → FULL; `out_data`/`out_id` held stable.
- `op_count` increments by 1 on each `out_valid && out_ready`, wrapping from 2^CNT_W−1 to 0.
- Reset values: `out_valid`=0, `out_data`=0, `out_id`=0, `rr_ptr`=0, `op_count`=0, state EMPTY. `req_ready` is all 0 during reset.
- Reset asserted mid-operation discards any held result immediately (asynchronously); no partial handshake completes.

## Timing
- Latency: 1 cycle from request accept edge to `out_valid`.
- Throughput: one result per cycle while `out_ready`=1 and any request is valid.
- Fairness: with all requesters continuously valid, each is granted once every NUM_REQ accepts.
- Outputs `out_*` and `op_count` are registered; `req_ready` is combinational.
- Reset deassertion: first accept can occur on the first rising edge after `rst` falls.

## Structure
- Package `shift_arb_pkg`: `shift_sel_e` enum (SH0, SH1, SH2, SH3, 2-bit), `slot_state_e` enum (EMPTY, FULL).
- Sub-module `shift_sel_unit` (combinational, parameter WIDTH): input x, `shift_sel_e` s, output result via case on s; default arm yields 0.
- Top level holds the round-robin pointer, grant logic, output register, FSM and counter.

## Test plan
- WIDTH=8: req0 data 0x13 sel 01, others idle, out_ready=1 → req_ready=0001 same cycle; next cycle out_valid=1, out_data=0x26, out_id=0; op_count 1 after handshake.
- Truncation: req2 data 0xFF sel 11 → out_data=0xF8, out_id=2.
- Fairness: all four valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1 on consecutive cycles, out_valid held high.
- Backpressure: out FULL with 0x40 id1, out_ready=0 for 5 cycles → out_data/out_id stable, req_ready=0000; raise out_ready → handshake, next granted request lands the same cycle (no bubble).
- Reset mid-operation: FULL, rr_ptr=3, assert rst between edges → out_valid drops to 0 immediately; after release, with all requesting, first grant is req0.
- Counter wrap with CNT_W=4: 17 completed handshakes → op_count reads 1.
